// File: rtl/multi_event_waiter.sv
// Arms a wait on a masked set of one-cycle event pulses and completes on ANY or ALL of them, with an optional cycle timeout.
// An event in ARMED cycle k gives done_o in cycle k+1; the result is held in DONE until ack_i, and arm_i is accepted only in IDLE or with ack_i in DONE.
module multi_event_waiter #(
    parameter int NUM_EVENTS = 3,
    parameter int TMO_W      = 16,
    parameter int IDX_W      = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm_i,
    input  logic                  mode_all_i,
    input  logic [NUM_EVENTS-1:0] mask_i,
    input  logic [TMO_W-1:0]      timeout_i,
    input  logic [NUM_EVENTS-1:0] ev_i,
    input  logic                  cancel_i,
    input  logic                  ack_i,
    output logic                  armed_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timed_out_o,
    output logic [NUM_EVENTS-1:0] hits_o,
    output logic [IDX_W-1:0]      first_idx_o,
    output logic                  arm_err_o
);

    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

    state_t                state, state_nxt;
    logic                  mode_all;
    logic [NUM_EVENTS-1:0] mask, hits, hits_nxt;
    logic [TMO_W-1:0]      tmo, cnt;
    logic [TMO_W:0]        cnt_inc;
    logic                  arm_slot, accept, reject;
    logic                  complete, tmo_fire, finish;
    logic [IDX_W-1:0]      idx_nxt;
    logic [NUM_EVENTS-1:0] res_hits;
    logic [IDX_W-1:0]      res_idx;
    logic                  res_tmo;
    logic                  armed_pulse, err_pulse;

    assign arm_slot = (state == IDLE) || ((state == DONE) && ack_i);
    assign accept   = arm_slot && arm_i && (|mask_i);
    assign reject   = arm_slot && arm_i && !(|mask_i);

    assign hits_nxt = hits | (ev_i & mask);
    assign complete = mode_all ? (hits_nxt == mask) : (|hits_nxt);
    // Widened so a saturated counter can never wrap into a false match.
    assign cnt_inc  = {1'b0, cnt} + {{TMO_W{1'b0}}, 1'b1};
    assign tmo_fire = (tmo != '0) && (cnt_inc == {1'b0, tmo});
    assign finish   = (state == ARMED) && !cancel_i && (complete || tmo_fire);

    always_comb begin
        idx_nxt = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            if (hits_nxt[i]) idx_nxt = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ARMED;
            ARMED: begin
                if (cancel_i)                  state_nxt = IDLE;
                else if (complete || tmo_fire) state_nxt = DONE;
            end
            DONE:    if (ack_i) state_nxt = accept ? ARMED : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_all    <= 1'b0;
            mask        <= '0;
            tmo         <= '0;
            hits        <= '0;
            cnt         <= '0;
            res_hits    <= '0;
            res_idx     <= '0;
            res_tmo     <= 1'b0;
            armed_pulse <= 1'b0;
            err_pulse   <= 1'b0;
        end else begin
            armed_pulse <= accept;
            err_pulse   <= reject;
            if (accept) begin
                mode_all <= mode_all_i;
                mask     <= mask_i;
                tmo      <= timeout_i;
                hits     <= '0;
                cnt      <= '0;
            end else if (state == ARMED) begin
                hits <= cancel_i ? '0 : hits_nxt;
                if (cnt != '1) cnt <= cnt_inc[TMO_W-1:0];
            end
            // A completion on the timeout cycle still reports as a completion.
            if (finish) begin
                res_hits <= hits_nxt;
                res_idx  <= idx_nxt;
                res_tmo  <= !complete;
            end
        end
    end

    always_comb begin
        busy_o      = (state == ARMED);
        done_o      = (state == DONE);
        armed_o     = armed_pulse;
        arm_err_o   = err_pulse;
        timed_out_o = done_o && res_tmo;
        hits_o      = done_o ? res_hits : '0;
        first_idx_o = done_o ? res_idx : '0;
    end

endmodule

// File: tb/tb_multi_event_waiter.sv
// Directed vector table plus hand-written multi-cycle sequences for multi_event_waiter.
module tb_multi_event_waiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm_i, mode_all_i, cancel_i, ack_i;
    logic [2:0]  mask_i, ev_i;
    logic [15:0] timeout_i;
    logic        armed, busy, done, timed_out, arm_err;
    logic [2:0]  hits;
    logic [1:0]  first_idx;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multi_event_waiter #(.NUM_EVENTS(3), .TMO_W(16)) dut (
        .clk(clk), .rst(rst),
        .arm_i(arm_i), .mode_all_i(mode_all_i), .mask_i(mask_i), .timeout_i(timeout_i),
        .ev_i(ev_i), .cancel_i(cancel_i), .ack_i(ack_i),
        .armed_o(armed), .busy_o(busy), .done_o(done), .timed_out_o(timed_out),
        .hits_o(hits), .first_idx_o(first_idx), .arm_err_o(arm_err)
    );

    // Output bundle: {armed, busy, done, timed_out, hits[2:0], first_idx[1:0], arm_err}
    function automatic logic [9:0] e(input logic a, b, d, t, input logic [2:0] h,
                                     input logic [1:0] i, input logic r);
        return {a, b, d, t, h, i, r};
    endfunction

    typedef struct {
        logic        arm, mode;
        logic [2:0]  mask;
        logic [15:0] tmo;
        logic [2:0]  ev;
        logic        cancel, ack;
        logic [9:0]  exp;
    } vec_t;

    function automatic vec_t mkv(input logic a, m, input logic [2:0] mk, input logic [15:0] t,
                                 input logic [2:0] ev, input logic c, k, input logic [9:0] x);
        vec_t v;
        v.arm = a; v.mode = m; v.mask = mk; v.tmo = t;
        v.ev = ev; v.cancel = c; v.ack = k; v.exp = x;
        return v;
    endfunction

    vec_t vecs[32];

    task automatic apply(input logic a, m, input logic [2:0] mk, input logic [15:0] t,
                         input logic [2:0] ev, input logic c, k);
        arm_i = a; mode_all_i = m; mask_i = mk; timeout_i = t;
        ev_i = ev; cancel_i = c; ack_i = k;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [9:0] exp);
        logic [9:0] got;
        got = {armed, busy, done, timed_out, hits, first_idx, arm_err};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got armed/busy/done/tmo/hits/idx/err=%b, expected %b", name, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;

        vecs[0]  = mkv(0, 0, 3'b000, 0, 3'b000, 0, 0, e(0, 0, 0, 0, 3'b000, 0, 0));
        vecs[1]  = mkv(1, 0, 3'b111, 0, 3'b001, 0, 0, e(1, 1, 0, 0, 3'b000, 0, 0));
        vecs[2]  = mkv(0, 0, 3'b000, 0, 3'b000, 0, 0, e(0, 1, 0, 0, 3'b000, 0, 0));
        vecs[3]  = mkv(0, 0, 3'b000, 0, 3'b010, 0, 0, e(0, 0, 1, 0, 3'b010, 1, 0));
        vecs[4]  = mkv(0, 0, 3'b000, 0, 3'b001, 0, 0, e(0, 0, 1, 0, 3'b010, 1, 0));
        vecs[5]  = mkv(1, 1, 3'b101, 0, 3'b000, 0, 1, e(1, 1, 0, 0, 3'b000, 0, 0));
        vecs[6]  = mkv(0, 0, 3'b000, 0, 3'b001, 0, 0, e(0, 1, 0, 0, 3'b000, 0, 0));
        vecs[7]  = mkv(0, 0, 3'b000, 0, 3'b010, 0, 0, e(0, 1, 0, 0, 3'b000, 0, 0));
        vecs[8]  = mkv(0, 0, 3'b000, 0, 3'b100, 0, 0, e(0, 0, 1, 0, 3'b101, 0, 0));
        vecs[9]  = mkv(0, 0, 3'b000, 0, 3'b000, 0, 1, e(0, 0, 0, 0, 3'b000, 0, 0));
        vecs[10] = mkv(1, 0, 3'b000, 0, 3'b000, 0, 0, e(0, 0, 0, 0, 3'b000, 0, 1));
        vecs[11] = mkv(0, 0, 3'b000, 0, 3'b000, 0, 0, e(0, 0, 0, 0, 3'b000, 0, 0));
        vecs[12] = mkv(1, 1, 3'b011, 3, 3'b000, 0, 0, e(1, 1, 0, 0, 3'b000, 0, 0));
        vecs[13] = mkv(0, 0, 3'b000, 0, 3'b010, 0, 0, e(0, 1, 0, 0, 3'b000, 0, 0));
        vecs[14] = mkv(0, 0, 3'b000, 0, 3'b000, 0, 0, e(0, 1, 0, 0, 3'b000, 0, 0));
        vecs[15] = mkv(0, 0, 3'b000, 0, 3'b000, 0, 0, e(0, 0, 1, 1, 3'b010, 1, 0));
        vecs[16] = mkv(0, 0, 3'b000, 0, 3'b000, 0, 1, e(0, 0, 0, 0, 3'b000, 0, 0));
        vecs[17] = mkv(1, 0, 3'b111, 2, 3'b000, 0, 0, e(1, 1, 0, 0, 3'b000, 0, 0));
        vecs[18] = mkv(0, 0, 3'b000, 0, 3'b000, 0, 0, e(0, 1, 0, 0, 3'b000, 0, 0));
        vecs[19] = mkv(0, 0, 3'b000, 0, 3'b100, 0, 0, e(0, 0, 1, 0, 3'b100, 2, 0));
        vecs[20] = mkv(0, 0, 3'b000, 0, 3'b000, 0, 1, e(0, 0, 0, 0, 3'b000, 0, 0));
        vecs[21] = mkv(1, 0, 3'b110, 0, 3'b000, 0, 0, e(1, 1, 0, 0, 3'b000, 0, 0));
        vecs[22] = mkv(0, 0, 3'b000, 0, 3'b001, 0, 0, e(0, 1, 0, 0, 3'b000, 0, 0));
        vecs[23] = mkv(0, 0, 3'b000, 0, 3'b010, 1, 0, e(0, 0, 0, 0, 3'b000, 0, 0));
        vecs[24] = mkv(0, 0, 3'b000, 0, 3'b000, 1, 1, e(0, 0, 0, 0, 3'b000, 0, 0));
        vecs[25] = mkv(1, 0, 3'b001, 0, 3'b000, 0, 0, e(1, 1, 0, 0, 3'b000, 0, 0));
        vecs[26] = mkv(0, 0, 3'b000, 0, 3'b111, 0, 0, e(0, 0, 1, 0, 3'b001, 0, 0));
        vecs[27] = mkv(1, 0, 3'b000, 0, 3'b000, 0, 1, e(0, 0, 0, 0, 3'b000, 0, 1));
        vecs[28] = mkv(0, 0, 3'b000, 0, 3'b000, 0, 0, e(0, 0, 0, 0, 3'b000, 0, 0));
        vecs[29] = mkv(1, 0, 3'b111, 0, 3'b000, 0, 0, e(1, 1, 0, 0, 3'b000, 0, 0));
        vecs[30] = mkv(0, 0, 3'b000, 0, 3'b110, 0, 0, e(0, 0, 1, 0, 3'b110, 1, 0));
        vecs[31] = mkv(0, 0, 3'b000, 0, 3'b000, 0, 1, e(0, 0, 0, 0, 3'b000, 0, 0));

        // Reset with an arm request pending: reset must win.
        rst = 1'b1;
        apply(1, 0, 3'b111, 0, 3'b111, 0, 0);
        apply(1, 0, 3'b111, 0, 3'b111, 0, 0);
        chk("reset", e(0, 0, 0, 0, 3'b000, 0, 0));
        rst = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i].arm, vecs[i].mode, vecs[i].mask, vecs[i].tmo,
                  vecs[i].ev, vecs[i].cancel, vecs[i].ack);
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // ANY, event on ARMED cycle 100.
        apply(1, 0, 3'b111, 0, 3'b000, 0, 0);
        chk("any100_arm", e(1, 1, 0, 0, 3'b000, 0, 0));
        idle(99);
        chk("any100_wait", e(0, 1, 0, 0, 3'b000, 0, 0));
        apply(0, 0, 3'b000, 0, 3'b001, 0, 0);
        chk("any100_done", e(0, 0, 1, 0, 3'b001, 0, 0));
        apply(0, 0, 3'b000, 0, 3'b000, 0, 1);
        chk("any100_ack", e(0, 0, 0, 0, 3'b000, 0, 0));

        // Three sequenced rounds, events A, B, C 100 cycles after armed_o.
        for (int r = 0; r < 3; r++) begin
            logic [2:0] evr;
            evr = 3'b001 << r;
            apply(1, 0, 3'b111, 0, 3'b000, 0, 0);
            chk($sformatf("round%0d_arm", r), e(1, 1, 0, 0, 3'b000, 0, 0));
            quiet = 0;
            for (int c = 0; c < 99; c++) begin
                apply(0, 0, 3'b000, 0, 3'b000, 0, 0);
                if (done || !busy) quiet++;
            end
            n_vec++;
            if (quiet != 0) begin
                n_bad++;
                $display("FAIL round%0d_quiet: %0d cycles left ARMED early, expected 0", r, quiet);
            end
            apply(0, 0, 3'b000, 0, evr, 0, 0);
            chk($sformatf("round%0d_done", r), e(0, 0, 1, 0, evr, 2'(r), 0));
            apply(0, 0, 3'b000, 0, 3'b000, 0, 1);
            chk($sformatf("round%0d_ack", r), e(0, 0, 0, 0, 3'b000, 0, 0));
        end

        // Timeout of 5 with no events: done on the 6th cycle after the arm cycle.
        apply(1, 0, 3'b111, 5, 3'b000, 0, 0);
        idle(4);
        chk("tmo5_wait", e(0, 1, 0, 0, 3'b000, 0, 0));
        idle(1);
        chk("tmo5_done", e(0, 0, 1, 1, 3'b000, 0, 0));
        apply(0, 0, 3'b000, 0, 3'b000, 0, 1);

        // Same timeout, event lands on ARMED cycle 5: completion wins.
        apply(1, 0, 3'b111, 5, 3'b000, 0, 0);
        idle(4);
        apply(0, 0, 3'b000, 0, 3'b010, 0, 0);
        chk("tmo5_ev_done", e(0, 0, 1, 0, 3'b010, 1, 0));
        apply(0, 0, 3'b000, 0, 3'b000, 0, 1);

        // Reset mid-wait, then a normal wait.
        apply(1, 0, 3'b111, 0, 3'b000, 0, 0);
        idle(3);
        rst = 1'b1;
        apply(0, 0, 3'b000, 0, 3'b001, 0, 0);
        chk("rst_mid", e(0, 0, 0, 0, 3'b000, 0, 0));
        rst = 1'b0;
        apply(1, 0, 3'b100, 0, 3'b000, 0, 0);
        chk("post_rst_arm", e(1, 1, 0, 0, 3'b000, 0, 0));
        apply(0, 0, 3'b000, 0, 3'b100, 0, 0);
        chk("post_rst_done", e(0, 0, 1, 0, 3'b100, 2, 0));
        apply(0, 0, 3'b000, 0, 3'b000, 0, 1);
        chk("post_rst_ack", e(0, 0, 0, 0, 3'b000, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
